// File: rtl/hmac_param_core.sv
// HMAC sequencing core between the message FIFO/register block and a SHA-2 engine.
// Emits ipad/opad blocks, feeds the inner digest back for the outer hash, and passes through when hmac_en=0.
module hmac_param_core #(
  parameter int BlockSize   = 1024,
  parameter int KeyWidth    = 1024,
  parameter int DigestWidth = 512,
  parameter int WordWidth   = 32,
  parameter int LenWidth    = 128
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [KeyWidth-1:0]                      secret_key,
  input  logic [$clog2(KeyWidth/WordWidth+1)-1:0]  key_words,
  input  logic [$clog2(DigestWidth/WordWidth+1)-1:0] digest_words,
  input  logic                                     hmac_en,
  input  logic                                     reg_hash_start,
  input  logic                                     reg_hash_process,
  input  logic                                     reg_abort,
  output logic                                     hash_done,
  output logic                                     busy,
  output logic                                     err_cfg,
  output logic                                     sha_hash_start,
  output logic                                     sha_hash_process,
  input  logic                                     sha_hash_done,
  output logic                                     sha_rvalid,
  output logic [WordWidth-1:0]                     sha_rdata,
  output logic [WordWidth/8-1:0]                   sha_rmask,
  input  logic                                     sha_rready,
  input  logic                                     fifo_rvalid,
  input  logic [WordWidth-1:0]                     fifo_rdata,
  input  logic [WordWidth/8-1:0]                   fifo_rmask,
  output logic                                     fifo_rready,
  output logic                                     fifo_wsel,
  output logic                                     fifo_wvalid,
  output logic [$clog2(DigestWidth/WordWidth)-1:0] fifo_wdata_sel,
  input  logic                                     fifo_wready,
  input  logic [LenWidth-1:0]                      message_length,
  output logic [LenWidth-1:0]                      sha_message_length
);

  localparam int KeyWordsMax = KeyWidth / WordWidth;
  localparam int DigWordsMax = DigestWidth / WordWidth;
  localparam int BlkWords    = BlockSize / WordWidth;
  localparam int KwW         = $clog2(KeyWordsMax + 1);
  localparam int DwW         = $clog2(DigWordsMax + 1);
  localparam int SelW        = $clog2(DigWordsMax);
  localparam int MaskW       = WordWidth / 8;
  localparam int LsbW        = $clog2(WordWidth);
  localparam int PadIdxW     = $clog2(BlkWords);

  typedef enum logic [2:0] {
    StIdle, StIPad, StMsg, StWaitResp, StPush, StOPad, StDone
  } state_e;

  typedef enum logic {RndInner, RndOuter} round_e;

  state_e               state_q, state_d;
  round_e               round_q;
  logic [LenWidth-1:0]  txcount_q;
  logic [SelW-1:0]      wr_idx_q;
  logic                 process_q;
  logic [KwW-1:0]       key_words_q;
  logic [DwW-1:0]       digest_words_q;

  logic                 h_sha_start, h_sha_process, h_done, h_err;
  logic                 h_rvalid, h_fifo_rready, h_wsel, h_wvalid;
  logic [WordWidth-1:0] h_rdata;
  logic [MaskW-1:0]     h_rmask;
  logic [SelW-1:0]      h_wdata_sel;
  logic                 start_accept, push_last;

  logic                 cfg_bad, len_met, pad_done;
  logic [LenWidth-1:0]  inner_len, outer_len, hmac_len;
  logic [PadIdxW-1:0]   pad_idx;
  logic [WordWidth-1:0] key_word;

  function automatic logic [LenWidth-1:0] mask_bits(input logic [MaskW-1:0] m);
    logic [LenWidth-1:0] n;
    n = '0;
    for (int i = 0; i < MaskW; i++) begin
      if (m[i]) n = n + LenWidth'(8);
    end
    return n;
  endfunction

  assign cfg_bad   = (digest_words == '0) || (int'(digest_words) > DigWordsMax) ||
                     (int'(key_words) > KeyWordsMax);
  assign inner_len = message_length + LenWidth'(BlockSize);
  assign outer_len = LenWidth'(BlockSize) + LenWidth'(digest_words_q) * LenWidth'(WordWidth);
  assign hmac_len  = (round_q == RndOuter) ? outer_len : inner_len;
  assign len_met   = txcount_q >= hmac_len;
  assign pad_done  = txcount_q == LenWidth'(BlockSize);
  // Pad words are always full, so the bit count doubles as the pad word index.
  assign pad_idx   = txcount_q[LsbW +: PadIdxW];

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    key_word = '0;
    for (int i = 0; i < KeyWordsMax; i++) begin
      if (i == int'(pad_idx) && i < int'(key_words_q)) begin
        key_word = secret_key[KeyWidth-1-i*WordWidth -: WordWidth];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    h_sha_start   = 1'b0;
    h_sha_process = 1'b0;
    h_done        = 1'b0;
    h_err         = 1'b0;
    h_rvalid      = 1'b0;
    h_fifo_rready = 1'b0;
    h_wsel        = 1'b0;
    h_wvalid      = 1'b0;
    h_rdata       = '0;
    h_rmask       = '0;
    h_wdata_sel   = '0;
    start_accept  = 1'b0;
    push_last     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hmac_en && reg_hash_start) begin
          if (cfg_bad) begin
            h_err = 1'b1;
          end else begin
            start_accept = 1'b1;
            h_sha_start  = 1'b1;
            state_d      = StIPad;
          end
        end
      end
      StIPad, StOPad: begin
        h_wsel = (state_q == StOPad);
        if (pad_done) begin
          state_d = StMsg;
        end else begin
          h_rvalid = 1'b1;
          h_rmask  = '1;
          h_rdata  = key_word ^ ((state_q == StIPad) ? {MaskW{8'h36}} : {MaskW{8'h5c}});
        end
      end
      StMsg: begin
        // Once the length is met no further FIFO word is consumed.
        if (!len_met) begin
          h_rvalid      = fifo_rvalid;
          h_fifo_rready = sha_rready;
          h_rdata       = fifo_rdata;
          h_rmask       = fifo_rmask;
        end
        if (round_q == RndOuter) begin
          h_wsel = 1'b1;
          if (len_met) begin
            h_sha_process = 1'b1;
            state_d       = StWaitResp;
          end
        end else if (process_q && len_met) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (sha_hash_done) state_d = (round_q == RndInner) ? StPush : StDone;
      end
      StPush: begin
        h_wsel      = 1'b1;
        h_wvalid    = 1'b1;
        h_wdata_sel = wr_idx_q;
        if (fifo_wready && (DwW'(wr_idx_q) == digest_words_q - DwW'(1))) begin
          push_last   = 1'b1;
          h_sha_start = 1'b1;
          state_d     = StOPad;
        end
      end
      StDone: begin
        h_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && round_q == RndInner && reg_hash_process) h_sha_process = 1'b1;

    if (reg_abort) begin
      state_d       = StIdle;
      h_sha_start   = 1'b0;
      h_sha_process = 1'b0;
      h_done        = 1'b0;
      h_err         = 1'b0;
      h_rvalid      = 1'b0;
      h_fifo_rready = 1'b0;
      h_wsel        = 1'b0;
      h_wvalid      = 1'b0;
      h_rdata       = '0;
      h_rmask       = '0;
      h_wdata_sel   = '0;
      start_accept  = 1'b0;
      push_last     = 1'b0;
    end
  end

  always_comb begin
    if (hmac_en) begin
      sha_hash_start     = h_sha_start;
      sha_hash_process   = h_sha_process;
      hash_done          = h_done;
      sha_rvalid         = h_rvalid;
      sha_rdata          = h_rdata;
      sha_rmask          = h_rmask;
      fifo_rready        = h_fifo_rready;
      fifo_wsel          = h_wsel;
      fifo_wvalid        = h_wvalid;
      fifo_wdata_sel     = h_wdata_sel;
      sha_message_length = (state_q != StIdle && !reg_abort) ? hmac_len : '0;
    end else begin
      sha_hash_start     = reg_hash_start;
      sha_hash_process   = reg_hash_process;
      hash_done          = sha_hash_done;
      sha_rvalid         = fifo_rvalid;
      sha_rdata          = fifo_rdata;
      sha_rmask          = fifo_rmask;
      fifo_rready        = sha_rready;
      fifo_wsel          = 1'b0;
      fifo_wvalid        = 1'b0;
      fifo_wdata_sel     = '0;
      sha_message_length = message_length;
    end
  end

  assign busy    = (state_q != StIdle);
  assign err_cfg = h_err;

  // NOTE: asynchronous active-low reset; every register returns to its idle value the moment rst_ni falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      round_q        <= RndInner;
      txcount_q      <= '0;
      wr_idx_q       <= '0;
      process_q      <= 1'b0;
      key_words_q    <= '0;
      digest_words_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q <= state_d;
      if (reg_abort) begin
        round_q   <= RndInner;
        txcount_q <= '0;
        wr_idx_q  <= '0;
        process_q <= 1'b0;
      end else begin
        if (start_accept) begin
          key_words_q    <= key_words;
          digest_words_q <= digest_words;
          round_q        <= RndInner;
        end else if (push_last) begin
          round_q <= RndOuter;
        end

        if (start_accept || push_last) begin
          txcount_q <= '0;
        end else if (sha_rvalid && sha_rready) begin
          txcount_q <= txcount_q + mask_bits(sha_rmask);
        end

        if (push_last) begin
          wr_idx_q <= '0;
        end else if (fifo_wvalid && fifo_wready) begin
          wr_idx_q <= wr_idx_q + SelW'(1);
        end

        if (start_accept || h_done) begin
          process_q <= 1'b0;
        end else if (hmac_en && state_q != StIdle && reg_hash_process) begin
          process_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hmac_param_core.sv
// Randomised self-checking bench for hmac_param_core: the bench plays FIFO and SHA engine and
// compares every word reaching the SHA port with a stream built directly from the HMAC rules.
module tb_hmac_param_core;

  localparam int BlockSize   = 1024;
  localparam int KeyWidth    = 1024;
  localparam int DigestWidth = 512;
  localparam int WordWidth   = 32;
  localparam int LenWidth    = 128;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
  } word_t;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [KeyWidth-1:0] secret_key;
  logic [5:0]          key_words;
  logic [4:0]          digest_words;
  logic                hmac_en, reg_hash_start, reg_hash_process, reg_abort;
  logic                hash_done, busy, err_cfg;
  logic                sha_hash_start, sha_hash_process, sha_hash_done;
  logic                sha_rvalid, sha_rready;
  logic [31:0]         sha_rdata;
  logic [3:0]          sha_rmask;
  logic                fifo_rvalid, fifo_rready;
  logic [31:0]         fifo_rdata;
  logic [3:0]          fifo_rmask;
  logic                fifo_wsel, fifo_wvalid, fifo_wready;
  logic [3:0]          fifo_wdata_sel;
  logic [127:0]        message_length, sha_message_length;

  hmac_param_core #(
    .BlockSize(BlockSize), .KeyWidth(KeyWidth), .DigestWidth(DigestWidth),
    .WordWidth(WordWidth), .LenWidth(LenWidth)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .secret_key(secret_key), .key_words(key_words),
    .digest_words(digest_words), .hmac_en(hmac_en), .reg_hash_start(reg_hash_start),
    .reg_hash_process(reg_hash_process), .reg_abort(reg_abort), .hash_done(hash_done),
    .busy(busy), .err_cfg(err_cfg), .sha_hash_start(sha_hash_start),
    .sha_hash_process(sha_hash_process), .sha_hash_done(sha_hash_done),
    .sha_rvalid(sha_rvalid), .sha_rdata(sha_rdata), .sha_rmask(sha_rmask),
    .sha_rready(sha_rready), .fifo_rvalid(fifo_rvalid), .fifo_rdata(fifo_rdata),
    .fifo_rmask(fifo_rmask), .fifo_rready(fifo_rready), .fifo_wsel(fifo_wsel),
    .fifo_wvalid(fifo_wvalid), .fifo_wdata_sel(fifo_wdata_sel), .fifo_wready(fifo_wready),
    .message_length(message_length), .sha_message_length(sha_message_length)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  word_t        fq[$];
  word_t        cap[$];
  int           wr_log[$];
  logic [127:0] lens[$];
  int           n_start, n_done, cnt;
  logic [127:0] sha_bits;
  bit           proc;
  bit           req_start, req_process, req_abort;
  logic         s_err, s_start, s_wvalid;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t mk(input logic [31:0] d, input logic [3:0] m);
    word_t w;
    w.d = d;
    w.m = m;
    return w;
  endfunction

  function automatic logic [31:0] dig_word(input logic [3:0] i);
    return 32'hD16E5700 | {28'h0, i};
  endfunction

  task automatic clear_model();
    fq.delete(); cap.delete(); wr_log.delete(); lens.delete();
    n_start = 0; n_done = 0; cnt = 0; sha_bits = '0; proc = 0;
  endtask

  // One clock: drive FIFO/SHA/register inputs, sample away from the edge, advance the models.
  task automatic tick();
    reg_hash_start   = req_start;
    reg_hash_process = req_process;
    reg_abort        = req_abort;
    req_start = 0; req_process = 0; req_abort = 0;
    sha_rready = ($urandom_range(0, 3) != 0);
    if (fq.size() > 0 && $urandom_range(0, 3) != 0) begin
      fifo_rvalid = 1'b1; fifo_rdata = fq[0].d; fifo_rmask = fq[0].m;
    end else begin
      fifo_rvalid = 1'b0; fifo_rdata = $urandom; fifo_rmask = 4'hf;
    end
    fifo_wready   = ($urandom_range(0, 2) != 0);
    sha_hash_done = (cnt == 1);
    #1;
    s_err = err_cfg; s_start = sha_hash_start; s_wvalid = fifo_wvalid;
    if (fifo_rvalid && fifo_rready) void'(fq.pop_front());
    if (sha_rvalid && sha_rready) begin
      cap.push_back(mk(sha_rdata, sha_rmask));
      sha_bits += 128'(8 * $countones(sha_rmask));
    end
    if (fifo_wvalid && fifo_wready) begin
      wr_log.push_back(int'(fifo_wdata_sel));
      fq.push_back(mk(dig_word(fifo_wdata_sel), 4'hf));
    end
    if (sha_hash_start) begin n_start++; sha_bits = '0; proc = 0; end
    if (sha_hash_process) proc = 1;
    if (hash_done) n_done++;
    if (cnt > 0) cnt--;
    if (sha_hash_done) begin
      lens.push_back(sha_message_length);
      proc = 0;
    end else if (cnt == 0 && proc && sha_bits >= sha_message_length) begin
      cnt = 3;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic run_hmac(input int kw, input int dw, input int nw, input logic [3:0] lastm,
                          input bit fixed, input int abort_after);
    word_t         exp[$];
    word_t         msg[$];
    logic [1023:0] key;
    logic [31:0]   kword;
    logic [127:0]  mlen;
    clear_model();
    if (fixed) key = {128{8'h0b}};
    else for (int i = 0; i < 32; i++) key[i*32 +: 32] = $urandom;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] d;
      d = fixed ? ((i == 0) ? 32'h48692054 : 32'h68657265) : $urandom;
      msg.push_back(mk(d, (i == nw - 1) ? lastm : 4'hf));
    end
    mlen = 128'(32 * (nw - 1) + 8 * $countones(lastm));
    foreach (msg[i]) fq.push_back(msg[i]);
    hmac_en = 1'b1; secret_key = key; message_length = mlen;
    key_words = 6'(kw); digest_words = 5'(dw);
    req_start = 1; tick();
    key_words = 6'($urandom); digest_words = 5'($urandom);
    tick();
    req_process = 1; tick();
    for (int c = 0; c < 3000 && n_done == 0; c++) begin
      if (abort_after >= 0 && wr_log.size() == abort_after) break;
      tick();
    end
    if (abort_after >= 0) begin
      check("abort_writes", wr_log.size(), abort_after);
      req_abort = 1; tick();
      check("abort_wvalid", s_wvalid, 0);
      check("abort_busy", busy, 0);
      repeat (20) tick();
      check("abort_no_done", n_done, 0);
      clear_model();
      return;
    end
    repeat (5) tick();
    check("done_count", n_done, 1);
    check("busy_after", busy, 0);
    check("start_count", n_start, 2);
    check("write_count", wr_log.size(), dw);
    foreach (wr_log[i]) check("write_index", wr_log[i], i);
    check("len_count", lens.size(), 2);
    if (lens.size() >= 2) begin
      check("len_inner", lens[0], mlen + 128'(BlockSize));
      check("len_outer", lens[1], 128'(BlockSize + dw * WordWidth));
    end
    for (int i = 0; i < 32; i++) begin
      kword = (i < kw) ? key[1023-32*i -: 32] : 32'h0;
      exp.push_back(mk(kword ^ 32'h36363636, 4'hf));
    end
    foreach (msg[i]) exp.push_back(msg[i]);
    for (int i = 0; i < 32; i++) begin
      kword = (i < kw) ? key[1023-32*i -: 32] : 32'h0;
      exp.push_back(mk(kword ^ 32'h5c5c5c5c, 4'hf));
    end
    for (int i = 0; i < dw; i++) exp.push_back(mk(dig_word(4'(i)), 4'hf));
    check("word_count", cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      check("sha_word", {cap[i].d, cap[i].m}, {exp[i].d, exp[i].m});
    end
  endtask

  initial begin
    logic [3:0]   pm;
    logic [127:0] ml;
    rst_ni = 1'b0; hmac_en = 1'b1; secret_key = '0; key_words = '0; digest_words = '0;
    reg_hash_start = 0; reg_hash_process = 0; reg_abort = 0; sha_hash_done = 0;
    sha_rready = 0; fifo_rvalid = 0; fifo_rdata = '0; fifo_rmask = '0; fifo_wready = 0;
    message_length = '0;
    req_start = 0; req_process = 0; req_abort = 0;
    clear_model();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", hash_done, 0);
    check("rst_start", sha_hash_start, 0);
    check("rst_rvalid", sha_rvalid, 0);
    check("rst_wsel", fifo_wsel, 0);
    check("rst_wvalid", fifo_wvalid, 0);
    check("rst_len", sha_message_length, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    hmac_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pm = (i == 2) ? 4'h3 : 4'hf;
      ml = {$urandom, $urandom, $urandom, $urandom};
      fifo_rvalid = 1'b1; fifo_rdata = 32'hA5A5A5A5; fifo_rmask = pm;
      sha_rready = (i != 1); message_length = ml; sha_hash_done = (i == 1);
      reg_hash_start = (i == 0); reg_hash_process = (i == 2);
      #1;
      check("pt_rvalid", sha_rvalid, 1);
      check("pt_rdata", sha_rdata, 32'hA5A5A5A5);
      check("pt_rmask", sha_rmask, pm);
      check("pt_rready", fifo_rready, (i != 1));
      check("pt_len", sha_message_length, ml);
      check("pt_done", hash_done, (i == 1));
      check("pt_start", sha_hash_start, (i == 0));
      check("pt_process", sha_hash_process, (i == 2));
      @(posedge clk_i); #1;
    end
    check("pt_busy", busy, 0);

    run_hmac(5, 16, 2, 4'hf, 1, -1);
    run_hmac(5, 8, 3, 4'hf, 0, -1);
    run_hmac(7, 4, 2, 4'h3, 0, -1);

    hmac_en = 1'b1;
    key_words = 6'd4; digest_words = 5'd0; req_start = 1; tick();
    check("cfg0_err", s_err, 1); check("cfg0_start", s_start, 0); check("cfg0_busy", busy, 0);
    tick();
    check("cfg_pulse", s_err, 0);
    digest_words = 5'd17; req_start = 1; tick();
    check("cfg17_err", s_err, 1); check("cfg17_start", s_start, 0); check("cfg17_busy", busy, 0);
    key_words = 6'd33; digest_words = 5'd4; req_start = 1; tick();
    check("cfgkw_err", s_err, 1); check("cfgkw_busy", busy, 0);

    run_hmac(12, 16, 4, 4'hf, 0, 3);
    run_hmac(3, 16, 2, 4'h1, 0, -1);

    key_words = 6'd4; digest_words = 5'd4; req_start = 1; req_abort = 1; tick();
    check("prio_start", s_start, 0); check("prio_busy", busy, 0);
    run_hmac(32, 5, 1, 4'h7, 0, -1);

    for (int r = 0; r < 4; r++) begin
      run_hmac($urandom_range(0, 32), $urandom_range(1, 16), $urandom_range(1, 5),
               4'($urandom_range(1, 15)) | 4'h1, 0, -1);
    end

    key_words = 6'd2; digest_words = 5'd2; message_length = 128'd32; req_start = 1; tick();
    repeat (5) tick();
    check("mid_busy", busy, 1);
    rst_ni = 1'b0; #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_rvalid", sha_rvalid, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    clear_model();
    run_hmac(9, 3, 2, 4'hf, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hmac_param_core.md
Name: hmac_param_core

Overview:
Parametrised HMAC sequencing core that sits between the message FIFO/register block and a SHA-2 engine. It supports SHA-256 and SHA-512 geometry through the BlockSize and DigestWidth parameters. At run time it takes a configurable key length and a configurable inner-digest feedback length (truncated digests). It adds byte-accurate transfer counting, abort, and configuration-error detection. With hmac_en low it is a transparent pass-through to the SHA engine.

Parameters:
BlockSize, 1024, hash block size in bits (512 or 1024)
KeyWidth, 1024, maximum key width in bits; must be at most BlockSize and a multiple of WordWidth
DigestWidth, 512, maximum digest width in bits
WordWidth, 32, FIFO/SHA data word width in bits
LenWidth, 128, message-length width in bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
secret_key  in  KeyWidth  key, MSW first; only the top key_words words are used
key_words  in  $clog2(KeyWidth/WordWidth+1)  key length in words
digest_words  in  $clog2(DigestWidth/WordWidth+1)  inner-digest words fed back to the outer hash
hmac_en  in  1  HMAC mode enable
reg_hash_start  in  1  start pulse from register
reg_hash_process  in  1  message-complete pulse from register
reg_abort  in  1  abort pulse
hash_done  out  1  completion pulse
busy  out  1  high in any state other than StIdle
err_cfg  out  1  one-cycle pulse on rejected start
sha_hash_start  out  1  to SHA
sha_hash_process  out  1  to SHA
sha_hash_done  in  1  from SHA
sha_rvalid  out  1  data valid to SHA
sha_rdata  out  WordWidth  data to SHA
sha_rmask  out  WordWidth/8  byte mask to SHA
sha_rready  in  1  SHA accepts data
fifo_rvalid  in  1  FIFO data valid
fifo_rdata  in  WordWidth  FIFO data
fifo_rmask  in  WordWidth/8  FIFO byte mask
fifo_rready  out  1  FIFO pop
fifo_wsel  out  1  FIFO write source: 0 = register, 1 = digest
fifo_wvalid  out  1  digest write valid
fifo_wdata_sel  out  $clog2(DigestWidth/WordWidth)  digest word index
fifo_wready  in  1  FIFO accepts write
message_length  in  LenWidth  message length in bits
sha_message_length  out  LenWidth  length to SHA

Behaviour:
- Reset values: all outputs 0; internal state StIdle, round Inner, txcount 0.
- hmac_en=0 (pass-through):
  - sha_hash_start = reg_hash_start; sha_hash_process = reg_hash_process; hash_done = sha_hash_done.
  - FIFO read port wired straight to the SHA read port; sha_message_length = message_length.
  - Pass-through path is combinational, zero latency.
- Pad words:
  - Key zero-extended to BlockSize; words at index >= key_words are treated as zero.
  - ipad word = keyword ^ 0x36 repeated per byte; opad word = keyword ^ 0x5c repeated per byte.
  - Pad words are sent with mask all-ones.
- txcount: LenWidth bits. Clears on entry to StIPad and StOPad. On each sha_rvalid&&sha_rready it adds 8*popcount(sha_rmask).
- sha_message_length in HMAC mode:
  - Inner round: message_length + BlockSize, truncated to LenWidth.
  - Outer round: BlockSize + digest_words_q*WordWidth.
- Configuration latch: key_words and digest_words are latched at an accepted start (_q copies); later changes are ignored until the next start.
- State machine:
  - StIdle: on hmac_en && reg_hash_start:
    - If digest_words==0, digest_words>DigestWidth/WordWidth, or key_words>KeyWidth/WordWidth: pulse err_cfg and stay in StIdle. No sha_hash_start.
    - Otherwise: sha_hash_start=1, round=Inner, go to StIPad.
  - StIPad: sha_rvalid=1 until txcount==BlockSize, then go to StMsg. sha_rvalid is never high in the cycle where the count is met.
  - StMsg:
    - fifo_rready = sha_rready; sha_rvalid = fifo_rvalid.
    - Inner round: leave when process_flag && txcount>=sha_message_length. process_flag sets on reg_hash_process (also if the pulse arrives during StIPad) and clears on start, abort or done.
    - Outer round: leave when txcount>=sha_message_length, asserting sha_hash_process for 1 cycle.
    - Either round goes to StWaitResp. Inner-round sha_hash_process is reg_hash_process OR'd through.
  - StWaitResp: on sha_hash_done, go to StPush (Inner) or StDone (Outer).
  - StPush:
    - fifo_wsel=1, fifo_wvalid=1; fifo_wdata_sel increments on each fifo_wready.
    - On fifo_wready with index == digest_words_q-1: clear index, sha_hash_start=1, round=Outer, go to StOPad.
  - StOPad: as StIPad with the opad word; fifo_wsel held 1. Then go to StMsg.
  - StDone: hash_done=1 for one cycle, go to StIdle.
- fifo_wsel is 1 in StPush, StOPad and outer StMsg; otherwise 0. fifo_wdata_sel is 0 outside StPush.
- reg_abort, from any state:
  - Go to StIdle next cycle; clear txcount, index, process_flag and round.
  - No hash_done. Outputs go inactive in that cycle.
  - Abort has priority over a simultaneous start; a start the cycle after abort is accepted.
- Reset mid-operation returns to the reset values above immediately (asynchronous).

Test Plan:
- Pass-through, hmac_en=0, 3 FIFO words 0xA5A5A5A5 -> identical words, masks and length seen at SHA; hash_done mirrors sha_hash_done.
- SHA-512, key_words=5 (key 0x0b repeated), digest_words=16, message_length=64, msg 0x48692054 0x68657265 -> 32 ipad words (first 0x3d3d3d3d, word 5 0x36363636); 16 digest writes; 32 opad words; outer length 1536; single hash_done.
- Truncated digest: digest_words=8 -> exactly 8 fifo_wvalid handshakes with indices 0..7; outer length 1280.
- Partial word: last FIFO mask 4'b0011, message_length=48 -> txcount reaches 1072 and StMsg exits on that word.
- Config error: digest_words=0 or 17 at start -> err_cfg pulse, busy stays 0, no sha_hash_start.
- Abort in StPush after 3 writes -> StIdle next cycle, no hash_done; new start yields a full correct run with fifo_wdata_sel starting at 0.
